// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle.
//   row_n     : keypad row lines, active-low, asynchronous to the scanner clock
//   col_n     : column drive, active-low one-hot
//   row, col  : encoded index of the accepted key
//   key_valid : one-cycle strobe when a new key is accepted
//   key_held  : high from acceptance until the release is debounced
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [1:0] row;
    logic [1:0] col;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_n,
        output col_n, row, col, key_valid, key_held
    );

    modport slave (
        output row_n,
        input  col_n, row, col, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchronizer and press/release debounce.
//   clk : system clock
//   rst : asynchronous reset, active-high
//   bus : keypad_scanner_if.master (row_n in; col_n, row, col, key_valid,
//         key_held out)
// One column is driven low at a time for SCAN_TICKS cycles. On the last tick
// the synchronized rows are sampled. A low row is debounced for
// DEBOUNCE_TICKS consecutive samples before the key is reported, and the
// release must be equally stable before scanning resumes.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 27000,
    parameter int DEBOUNCE_TICKS = 270000
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master bus
);

    localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DEB_DONE  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    sync1, rs;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [1:0]    col_idx, col_idx_nx;
    logic [1:0]    cap_row, cap_row_nx;
    logic [1:0]    row_q, row_nx;
    logic [1:0]    col_q, col_nx;
    logic          valid_q, valid_nx;
    logic          held_q, held_nx;
    logic [1:0]    first_low;

    // Lowest-index low row wins, so row 0 has highest priority.
    always_comb begin
        first_low = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!rs[i-1]) first_low = 2'(i - 1);
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        col_idx_nx = col_idx;
        cap_row_nx = cap_row;
        row_nx     = row_q;
        col_nx     = col_q;
        valid_nx   = 1'b0;
        held_nx    = held_q;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nx = '0;
                    if (rs != 4'b1111) begin
                        cap_row_nx = first_low;
                        state_nx   = DEBOUNCE;
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                    end
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            DEBOUNCE: begin
                // Acceptance is registered one cycle after the count completes.
                if (cnt == DEB_DONE) begin
                    row_nx   = cap_row;
                    col_nx   = col_idx;
                    valid_nx = 1'b1;
                    held_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HELD;
                end else if (!rs[cap_row]) begin
                    cnt_nx = cnt_inc;
                end else begin
                    cnt_nx   = '0;
                    state_nx = SCAN;
                end
            end
            HELD: begin
                // Only the captured row matters; other rows are ignored.
                if (cnt == DEB_DONE) begin
                    held_nx    = 1'b0;
                    col_idx_nx = col_idx + 2'd1;
                    cnt_nx     = '0;
                    state_nx   = SCAN;
                end else if (rs[cap_row]) begin
                    cnt_nx = cnt_inc;
                end else begin
                    cnt_nx = '0;
                end
            end
            default: begin
                state_nx = SCAN;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '1;
            rs      <= '1;
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= '0;
            cap_row <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1   <= bus.row_n;
            rs      <= sync1;
            state   <= state_nx;
            cnt     <= cnt_nx;
            col_idx <= col_idx_nx;
            cap_row <= cap_row_nx;
            row_q   <= row_nx;
            col_q   <= col_nx;
            valid_q <= valid_nx;
            held_q  <= held_nx;
        end
    end

    assign bus.col_n     = ~(4'b0001 << col_idx);
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.key_valid = valid_q;
    assign bus.key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines. It synchronizes and debounces the row inputs, then emits the encoded {row, col} index of a newly pressed key with a one-cycle strobe. It sits directly upstream of the keypad decoder, which turns row[1:0]/col[1:0] into the key code. Subsequent keys are ignored until the held key is released and debounced.

Parameters:
SCAN_TICKS, 27000, clock cycles each column is driven before its rows are sampled; must be >= 4 to cover line settling plus the 2-FF synchronizer.
DEBOUNCE_TICKS, 270000, number of consecutive stable synchronized samples required to accept a press or a release; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
row_n  input  4  keypad row lines, active-low (external pull-ups), asynchronous to clk
col_n  output  4  column drive, active-low one-hot
row  output  2  encoded row index of accepted key
col  output  2  encoded column index of accepted key
key_valid  output  1  one-cycle strobe: new key accepted, row/col valid
key_held  output  1  high from acceptance until release is debounced

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values: col_n=4'b1110 (column 0), row=0, col=0, key_valid=0, key_held=0, state=SCAN, column index=0, all counters=0, synchronizer flops=4'b1111.
- row_n passes through a 2-FF synchronizer (rs). All decisions use rs only.
- FSM states: SCAN, DEBOUNCE, HELD.
- SCAN: the tick counter runs from 0 to SCAN_TICKS-1 with the current column driven. On the last tick, rs is sampled:
  - any bit low -> capture the lowest-index low row (row 0 has highest priority), keep the column, clear the counter, go to DEBOUNCE;
  - otherwise advance the column index (3 wraps to 0), update col_n, clear the counter.
- DEBOUNCE: the column is held. Each cycle the captured row bit is checked:
  - low -> counter++;
  - high -> clear the counter, return to SCAN on the same column (full SCAN_TICKS again).
  - When the counter reaches DEBOUNCE_TICKS consecutive lows: in the next cycle row/col are loaded, key_valid=1 for exactly one cycle, key_held=1, and the FSM goes to HELD.
- HELD: the column is held. The captured row bit is checked:
  - high -> release counter++;
  - low -> release counter cleared.
  - After DEBOUNCE_TICKS consecutive highs: key_held=0, advance to the next column, go to SCAN.
  - Other rows going low in HELD are ignored.
- row/col change only in the cycle key_valid asserts and hold their values otherwise, including after release.
- key_valid never asserts twice for one continuous press; it never asserts in the same cycle as a key_held fall.
- Only one column is ever driven low. col_n is always one-hot-low, never 4'b1111 or multi-low.
- Reset asserted mid-operation (any state) forces all reset values immediately and asynchronously, with no strobe on deassertion.
- Counters sized $clog2(max(SCAN_TICKS, DEBOUNCE_TICKS)+1) and saturate at their terminal value.

Test Plan:
Bench uses SCAN_TICKS=4, DEBOUNCE_TICKS=8.
1. Reset, no keys pressed, 40 cycles -> col_n cycles 1110->1101->1011->0111->1110, 4 cycles each. key_valid is never high, row=col=0.
2. Hold row_n=1011 (row 2) while col_n=1101 (col 1), released 50 cycles later -> exactly one key_valid pulse with row=2, col=1; key_held stays high until 8 stable-high cycles after release, then scanning resumes at col 2.
3. Bounce: row_n bit 0 low for 3 cycles then high, during col 0 -> no key_valid, key_held=0, column 0 rescanned, then scan advances normally.
4. Release bounce: in HELD, row goes high for 5 cycles, low again, then high for 8 cycles -> key_held stays 1 through the bounce and falls only after the final 8 highs. No second key_valid.
5. Two keys: rows 1 and 3 low simultaneously on col 3 -> key_valid with row=1, col=3. Pressing row 0 on another column while held produces no strobe.
6. Reset asserted in HELD -> same cycle (asynchronous): key_held=0, key_valid=0, col_n=1110, row=col=0. After deassertion with the key still pressed, a fresh debounce is required before key_valid fires.
